// File: rtl/hamming_pkg.sv
// Shared widths, parity masks and syndrome-to-data-bit map for the Hamming(12,8) decoder.
package hamming_pkg;

    localparam int CW_W   = 12;
    localparam int DATA_W = 8;
    localparam int SYN_W  = 4;

    // Data bits covered by each parity bit p0..p3
    localparam logic [DATA_W-1:0] P0_MASK = 8'h5B;  // d0 d1 d3 d4 d6
    localparam logic [DATA_W-1:0] P1_MASK = 8'h6D;  // d0 d2 d3 d5 d6
    localparam logic [DATA_W-1:0] P2_MASK = 8'h8E;  // d1 d2 d3 d7
    localparam logic [DATA_W-1:0] P3_MASK = 8'hF0;  // d4 d5 d6 d7

    localparam logic [SYN_W-1:0] SYN_UNCORR_MIN = 4'd13;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SYN_W-1:0]  syn;
        logic              corrected;
        logic              uncorrectable;
    } dec_t;

    // One-hot flip mask for the data bit a syndrome points at; zero for parity/none/invalid.
    function automatic logic [DATA_W-1:0] syn_flip_mask(input logic [SYN_W-1:0] s);
        logic [DATA_W-1:0] m;
        m = '0;
        case (s)
            4'd3:    m = 8'h01;
            4'd5:    m = 8'h02;
            4'd6:    m = 8'h04;
            4'd7:    m = 8'h08;
            4'd9:    m = 8'h10;
            4'd10:   m = 8'h20;
            4'd11:   m = 8'h40;
            4'd12:   m = 8'h80;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome of a 12-bit codeword: stored parity xor recomputed parity.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  codeword,
    output logic [SYN_W-1:0] syndrome
);

    logic [DATA_W-1:0] d;
    logic [SYN_W-1:0]  p_calc;

    assign d = codeword[DATA_W-1:0];

    assign p_calc = {^(d & P3_MASK), ^(d & P2_MASK), ^(d & P1_MASK), ^(d & P0_MASK)};

    assign syndrome = codeword[CW_W-1:DATA_W] ^ p_calc;

endmodule

// File: rtl/hamming_decode_stage.sv
// Two-stage valid/ready Hamming(12,8) decoder with optional error counters.
// Counters exist only when HAMMING_DEC_STATS_EN is defined; otherwise they read 0.
module hamming_decode_stage
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_codeword,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SYN_W-1:0]  out_syndrome,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam int STAGES = 2;

    logic [STAGES:1]   vld_pipe;
    logic              s1_adv, s2_adv;
    logic [CW_W-1:0]   s1_cw;
    logic [SYN_W-1:0]  s1_syn;
    logic [SYN_W-1:0]  in_syn;
    dec_t              dec;

    hamming_syndrome u_syn (
        .codeword (in_codeword),
        .syndrome (in_syn)
    );

    assign s2_adv    = !vld_pipe[2] || out_ready;
    assign s1_adv    = !vld_pipe[1] || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_pipe[2];

    // S1: capture codeword with its syndrome
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            s1_cw       <= '0;
            s1_syn      <= '0;
        end else if (s1_adv) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) begin
                s1_cw  <= in_codeword;
                s1_syn <= in_syn;
            end
        end
    end

    // Parity bits are already folded into the syndrome
    logic unused_s1_par;
    assign unused_s1_par = ^s1_cw[CW_W-1:DATA_W];

    always_comb begin
        dec               = '0;
        dec.syn           = s1_syn;
        dec.uncorrectable = (s1_syn >= SYN_UNCORR_MIN);
        dec.corrected     = (s1_syn != '0) && !dec.uncorrectable;
        dec.data          = s1_cw[DATA_W-1:0] ^ syn_flip_mask(s1_syn);
    end

    // S2: registered result, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[2]       <= 1'b0;
            out_data          <= '0;
            out_syndrome      <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
        end else if (s2_adv) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                out_data          <= dec.data;
                out_syndrome      <= dec.syn;
                out_corrected     <= dec.corrected;
                out_uncorrectable <= dec.uncorrectable;
            end
        end
    end

`ifdef HAMMING_DEC_STATS_EN
    logic out_hs;
    assign out_hs = out_valid && out_ready;

    // Clear wins over a same-cycle increment; counts saturate at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (stat_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_hs) begin
            if (out_corrected && !(&corr_cnt))
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (out_uncorrectable && !(&uncorr_cnt))
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end
`else
    assign corr_cnt   = '0;
    assign uncorr_cnt = '0;

    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
`endif

endmodule

// File: tb/tb_hamming_decode_stage.sv
// Scoreboard bench for hamming_decode_stage: directed codewords, queue of expected words.
module tb_hamming_decode_stage;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] s;
        logic       c;
        logic       u;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [11:0]      in_codeword = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic [3:0]       out_syndrome;
    logic             out_corrected;
    logic             out_uncorrectable;
    logic             stat_clr = 1'b0;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    exp_t             q[$];
    int               errors = 0;
    int               checks = 0;
    logic [CNT_W-1:0] m_corr = '0;
    logic [CNT_W-1:0] m_unc = '0;
    logic             stall_prev = 1'b0;
    exp_t             prev_out, mon_cur, mon_e;

    always #5 clk = ~clk;

    hamming_decode_stage #(.CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_codeword       (in_codeword),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_syndrome      (out_syndrome),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable),
        .stat_clr          (stat_clr),
        .corr_cnt          (corr_cnt),
        .uncorr_cnt        (uncorr_cnt)
    );

    function automatic exp_t mk(input logic [7:0] d, input logic [3:0] s,
                                input logic c, input logic u);
        exp_t e;
        e.d = d; e.s = s; e.c = c; e.u = u;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every output handshake, verify hold during stalls, track counter model
    always @(negedge clk) begin
        if (!rst_n) begin
            m_corr     = '0;
            m_unc      = '0;
            stall_prev = 1'b0;
        end else begin
            mon_cur = mk(out_data, out_syndrome, out_corrected, out_uncorrectable);
            if (stall_prev)
                chk("stall_hold", 32'(mon_cur), 32'(prev_out));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got data=%h syn=%h with no word pending",
                             out_data, out_syndrome);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_word", 32'(mon_cur), 32'(mon_e));
`ifdef HAMMING_DEC_STATS_EN
                    if (!stat_clr) begin
                        if (mon_e.c && !(&m_corr)) m_corr = m_corr + 1'b1;
                        if (mon_e.u && !(&m_unc))  m_unc  = m_unc + 1'b1;
                    end
`endif
                end
            end
            if (stat_clr) begin
                m_corr = '0;
                m_unc  = '0;
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = mon_cur;
        end
    end

    task automatic send(input logic [11:0] cw, input exp_t e);
        int n;
        n = 0;
        in_valid    = 1'b1;
        in_codeword = cw;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck 0 for cw=%h", cw);
                in_valid = 1'b0;
                return;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_corr"},   32'(corr_cnt),   32'(m_corr));
        chk({name, "_uncorr"}, 32'(uncorr_cnt), 32'(m_unc));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_syn", out_syndrome, 0);
        chk("rst_flags", {out_corrected, out_uncorrectable}, 0);
        chk("rst_corr_cnt", corr_cnt, 0);
        chk("rst_uncorr_cnt", uncorr_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Clean word, 2-cycle latency
        send(12'h301, mk(8'h01, 4'd0, 1'b0, 1'b0));
        chk("lat_cycle1", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_cycle2", out_valid, 1);
        drain();

        // Single data-bit error, parity-bit error, double error
        send(12'h4A2, mk(8'hAA, 4'd7,  1'b1, 1'b0));
        send(12'hBFF, mk(8'hFF, 4'd8,  1'b1, 1'b0));
        send(12'hB03, mk(8'h03, 4'd13, 1'b0, 1'b1));
        send(12'h3FE, mk(8'hFF, 4'd3,  1'b1, 1'b0));
        send(12'h381, mk(8'h01, 4'd12, 1'b1, 1'b0));
        send(12'hD01, mk(8'h01, 4'd14, 1'b0, 1'b1));
        send(12'hC01, mk(8'h01, 4'd15, 1'b0, 1'b1));
        send(12'h201, mk(8'h01, 4'd1,  1'b1, 1'b0));
        drain();
        chk_cnt("mixed");

        // Backpressure: two words fill the pipe, third waits until release
        out_ready = 1'b0;
        send(12'h301, mk(8'h01, 4'd0, 1'b0, 1'b0));
        send(12'h4AA, mk(8'hAA, 4'd0, 1'b0, 1'b0));
        in_valid    = 1'b1;
        in_codeword = 12'h3FF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(12'h3FF, mk(8'hFF, 4'd0, 1'b0, 1'b0));
        drain();

        // Saturation of the corrected counter
        for (int i = 0; i < 17; i++)
            send(12'h4A2, mk(8'hAA, 4'd7, 1'b1, 1'b0));
        drain();
        chk_cnt("sat");
`ifdef HAMMING_DEC_STATS_EN
        chk("sat_all_ones", corr_cnt, {CNT_W{1'b1}});
`endif

        // Clear in the same cycle as an error handshake
        send(12'hB03, mk(8'h03, 4'd13, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        chk("clr_word_present", out_valid, 1);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        chk("clr_corr", corr_cnt, 0);
        chk("clr_uncorr", uncorr_cnt, 0);
        drain();

        // Reset with two words in flight
        send(12'h4A2, mk(8'hAA, 4'd7, 1'b1, 1'b0));
        send(12'hB03, mk(8'h03, 4'd13, 1'b0, 1'b1));
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_data", out_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_no_out", out_valid, 0);
        end
        chk_cnt("postrst");

        // Pipeline still healthy after reset
        send(12'h301, mk(8'h01, 4'd0, 1'b0, 1'b0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
